// File: rtl/goc_pkg.sv
// Shared types and constants for the GOC PWM transmitter.
// The optional preamble feature is enabled by defining GOC_PREAMBLE_EN.
package goc_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, PRE, SHIFT, DONE} goc_state_e;

   localparam int PHASES_PER_BIT = 3;

   // Phase patterns, first phase in the MSB
   localparam logic [PHASES_PER_BIT-1:0] PAT_ONE  = 3'b110;
   localparam logic [PHASES_PER_BIT-1:0] PAT_ZERO = 3'b100;

   // Pad level of phase 'ph' (0 = first phase) for a symbol carrying bit_val
   function automatic logic phase_level(input logic bit_val, input logic [1:0] ph);
      logic [PHASES_PER_BIT-1:0] pat;
      pat = bit_val ? PAT_ONE : PAT_ZERO;
      return pat[2'd2 - ph];
   endfunction

endpackage

// File: rtl/goc_sync_fifo.sv
// Single-clock FIFO with extra wrap bit on the pointers for full/empty.
// Read data is show-ahead: rd_data is the head entry whenever !empty.
module goc_sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data = mem[rd_ptr[AW-1:0]];
   // A push while full is refused even if a pop happens in the same cycle
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   // Pointer update, wraps naturally modulo 2*DEPTH
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/goc_pwm_tx.sv
// GOC optical-pad PWM transmitter: byte FIFO in front of an MSB-first
// 3-phase PWM serialiser. Define GOC_PREAMBLE_EN to prefix each frame
// with PREAMBLE_BITS '1' symbols.
module goc_pwm_tx
   import goc_pkg::*;
#(
   parameter int DATA_W        = 8,
   parameter int FIFO_DEPTH    = 16,
   parameter int SPEED_W       = 22,
   parameter int N_PADS        = 1,
   parameter int PREAMBLE_BITS = 8,
   localparam int PSEL_W       = (N_PADS > 1) ? $clog2(N_PADS) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [SPEED_W-1:0] goc_speed,
   input  logic [PSEL_W-1:0]  pad_sel,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_last,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               start_tx,
   output logic               busy,
   output logic               tx_done,
   output logic               underflow,
   output logic [N_PADS-1:0]  goc_pad
);
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   goc_state_e          state;
   logic [SPEED_W-1:0]  speed_q;
   logic [N_PADS-1:0]   pad_mask;
   logic [N_PADS-1:0]   sel_mask;
   logic [SPEED_W-1:0]  cnt;
   logic [1:0]          ph;
   logic [BW-1:0]       bit_idx;
   logic [DATA_W-1:0]   sr;
   logic                last_q;
   logic [DATA_W:0]     rd_data;
   logic                full;
   logic                empty;
   logic                pop;
   logic                end_of_bit;
`ifdef GOC_PREAMBLE_EN
   logic [$clog2(PREAMBLE_BITS):0] pre_cnt;
`endif

   assign in_ready = ~full;

   goc_sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (in_valid & in_ready),
      .wr_data ({in_last, in_data}),
      .pop     (pop),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty)
   );

   // One-hot of the requested pad; out-of-range selections map to no pad
   always_comb begin
      for (int i = 0; i < N_PADS; i++) sel_mask[i] = (pad_sel == PSEL_W'(i));
   end

   assign end_of_bit = (cnt == speed_q) && (ph == 2'(PHASES_PER_BIT - 1));
   // Pop in LOAD, and at a byte boundary when the frame continues
   assign pop = (state == LOAD) ||
                ((state == SHIFT) && end_of_bit && (bit_idx == '0) && !last_q && !empty);

   function automatic logic [N_PADS-1:0] drive(input logic lvl);
      return lvl ? pad_mask : '0;
   endfunction

   // Frame sequencer, phase/bit counters and registered pad drive
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         tx_done   <= 1'b0;
         underflow <= 1'b0;
         goc_pad   <= '0;
         speed_q   <= '0;
         pad_mask  <= '0;
         cnt       <= '0;
         ph        <= '0;
         bit_idx   <= '0;
         sr        <= '0;
         last_q    <= 1'b0;
`ifdef GOC_PREAMBLE_EN
         pre_cnt   <= '0;
`endif
      end else begin
         tx_done   <= 1'b0;
         underflow <= 1'b0;
         case (state)
            IDLE: begin
               if (start_tx && !empty) begin
                  state    <= LOAD;
                  busy     <= 1'b1;
                  speed_q  <= goc_speed;
                  pad_mask <= sel_mask;
               end
            end
            LOAD: begin
               sr      <= rd_data[DATA_W-1:0];
               last_q  <= rd_data[DATA_W];
               bit_idx <= BW'(DATA_W - 1);
               cnt     <= '0;
               ph      <= '0;
               goc_pad <= drive(1'b1);
`ifdef GOC_PREAMBLE_EN
               pre_cnt <= ($clog2(PREAMBLE_BITS)+1)'(PREAMBLE_BITS - 1);
               state   <= PRE;
`else
               state   <= SHIFT;
`endif
            end
`ifdef GOC_PREAMBLE_EN
            PRE: begin
               if (cnt != speed_q) begin
                  cnt <= cnt + 1'b1;
               end else if (!end_of_bit) begin
                  cnt     <= '0;
                  ph      <= ph + 1'b1;
                  goc_pad <= drive(phase_level(1'b1, ph + 2'd1));
               end else begin
                  // every symbol, preamble or data, starts high
                  cnt     <= '0;
                  ph      <= '0;
                  goc_pad <= drive(1'b1);
                  if (pre_cnt == '0) state <= SHIFT;
                  else               pre_cnt <= pre_cnt - 1'b1;
               end
            end
`endif
            SHIFT: begin
               if (cnt != speed_q) begin
                  cnt <= cnt + 1'b1;
               end else if (!end_of_bit) begin
                  cnt     <= '0;
                  ph      <= ph + 1'b1;
                  goc_pad <= drive(phase_level(sr[DATA_W-1], ph + 2'd1));
               end else begin
                  cnt <= '0;
                  ph  <= '0;
                  if (bit_idx != '0) begin
                     bit_idx <= bit_idx - 1'b1;
                     sr      <= sr << 1;
                     goc_pad <= drive(1'b1);
                  end else if (last_q) begin
                     state   <= DONE;
                     busy    <= 1'b0;
                     tx_done <= 1'b1;
                     goc_pad <= '0;
                  end else if (!empty) begin
                     // next byte follows with no idle cycle
                     sr      <= rd_data[DATA_W-1:0];
                     last_q  <= rd_data[DATA_W];
                     bit_idx <= BW'(DATA_W - 1);
                     goc_pad <= drive(1'b1);
                  end else begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     underflow <= 1'b1;
                     goc_pad   <= '0;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
